// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter (instruction fetch "if", load/store
// "ls") in front of one shared memory port, one transaction outstanding.
//
// Parameter
//   TIMEOUT    RESP cycles without mem_rvalid before the transaction is
//              aborted with an error response (2..255).
// Ports
//   clk, rst_n                       clock, asynchronous active-low reset
//   if_req, if_addr                  fetch request
//   if_gnt, if_rvalid, if_rdata,     fetch grant (combinational), response,
//   if_err                           response data, timeout flag
//   ls_req, ls_addr, ls_we, ls_wd    load/store request
//   ls_gnt, ls_rvalid, ls_rdata,     load/store grant, response, data,
//   ls_err                           timeout flag
//   mem_req, mem_addr, mem_we,       shared memory request channel
//   mem_wd, mem_ready
//   mem_rvalid, mem_rdata            shared memory response channel
//
// Build option
//   ARB_ROUND_ROBIN_EN  when defined, simultaneous requests alternate
//                       between the requesters; otherwise ls always wins.
module mem_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        ls_req,
  input  logic [31:0] ls_addr,
  input  logic        ls_we,
  input  logic [31:0] ls_wd,
  output logic        ls_gnt,
  output logic        ls_rvalid,
  output logic [31:0] ls_rdata,
  output logic        ls_err,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wd,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

  localparam logic [7:0] TO_VAL = 8'(TIMEOUT);

  state_e      state_q, state_d;
  logic        owner_q, owner_d;   // 1 = ls owns the transaction
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [31:0] wd_q, wd_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        if_rvalid_q, if_rvalid_d, if_err_q, if_err_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic        ls_rvalid_q, ls_rvalid_d, ls_err_q, ls_err_d;
  logic [31:0] ls_rdata_q, ls_rdata_d;
  logic        sel_ls;
  logic        rsp_fire, rsp_err;
  logic [31:0] rsp_data;
  logic [7:0]  cnt_inc;

`ifdef ARB_ROUND_ROBIN_EN
  logic        last_q, last_d;     // 1 = ls was granted last
  // On a tie the requester that was not granted last wins.
  assign sel_ls = ls_req && (!if_req || !last_q);
`else
  assign sel_ls = ls_req;
`endif

  assign cnt_inc = cnt_q + 8'd1;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wd_d        = wd_q;
    cnt_d       = cnt_q;
    if_rvalid_d = 1'b0;
    if_err_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    ls_rvalid_d = 1'b0;
    ls_err_d    = 1'b0;
    ls_rdata_d  = ls_rdata_q;
    if_gnt      = 1'b0;
    ls_gnt      = 1'b0;
    rsp_fire    = 1'b0;
    rsp_err     = 1'b0;
    rsp_data    = 32'd0;
`ifdef ARB_ROUND_ROBIN_EN
    last_d      = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (if_req || ls_req) begin
          owner_d = sel_ls;
          addr_d  = sel_ls ? ls_addr : if_addr;
          we_d    = sel_ls & ls_we;
          wd_d    = sel_ls ? ls_wd : 32'd0;
          if_gnt  = !sel_ls;
          ls_gnt  = sel_ls;
`ifdef ARB_ROUND_ROBIN_EN
          last_d  = sel_ls;
`endif
          state_d = REQ;
        end
      end
      REQ: begin
        if (mem_ready) begin
          cnt_d   = 8'd0;
          state_d = RESP;
        end
      end
      RESP: begin
        // A response arriving in the cycle the counter would expire wins.
        if (mem_rvalid) begin
          rsp_fire = 1'b1;
          rsp_data = mem_rdata;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TO_VAL) begin
            rsp_fire = 1'b1;
            rsp_err  = 1'b1;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (rsp_fire) begin
      if (owner_q) begin
        ls_rvalid_d = 1'b1;
        ls_err_d    = rsp_err;
        ls_rdata_d  = rsp_data;
      end else begin
        if_rvalid_d = 1'b1;
        if_err_d    = rsp_err;
        if_rdata_d  = rsp_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      addr_q      <= 32'd0;
      we_q        <= 1'b0;
      wd_q        <= 32'd0;
      cnt_q       <= 8'd0;
      if_rvalid_q <= 1'b0;
      if_err_q    <= 1'b0;
      if_rdata_q  <= 32'd0;
      ls_rvalid_q <= 1'b0;
      ls_err_q    <= 1'b0;
      ls_rdata_q  <= 32'd0;
`ifdef ARB_ROUND_ROBIN_EN
      last_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wd_q        <= wd_d;
      cnt_q       <= cnt_d;
      if_rvalid_q <= if_rvalid_d;
      if_err_q    <= if_err_d;
      if_rdata_q  <= if_rdata_d;
      ls_rvalid_q <= ls_rvalid_d;
      ls_err_q    <= ls_err_d;
      ls_rdata_q  <= ls_rdata_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_q      <= last_d;
`endif
    end
  end

  assign mem_req   = (state_q == REQ);
  assign mem_addr  = addr_q;
  assign mem_we    = we_q;
  assign mem_wd    = wd_q;
  assign if_rvalid = if_rvalid_q;
  assign if_err    = if_err_q;
  assign if_rdata  = if_rdata_q;
  assign ls_rvalid = ls_rvalid_q;
  assign ls_err    = ls_err_q;
  assign ls_rdata  = ls_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter. A memory responder
// answers mem_req with a programmable ready delay and response delay;
// each granted transaction pushes its expected response, and a monitor
// pops and compares it when an rvalid appears.
module tb_mem_arbiter;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, if_gnt, if_rvalid, if_err;
  logic [31:0] if_addr, if_rdata;
  logic        ls_req, ls_we, ls_gnt, ls_rvalid, ls_err;
  logic [31:0] ls_addr, ls_wd, ls_rdata;
  logic        mem_req, mem_we, mem_ready, mem_rvalid;
  logic [31:0] mem_addr, mem_wd, mem_rdata;

  mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
    .ls_req(ls_req), .ls_addr(ls_addr), .ls_we(ls_we), .ls_wd(ls_wd),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .ls_err(ls_err),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wd(mem_wd), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] act,
                          input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  typedef struct {
    bit          ls;
    logic [31:0] data;
    bit          err;
    int          lat;
  } exp_t;

  exp_t sb[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory responder configuration (written by the stimulus process).
  int          m_rdy = 0;
  int          m_rv = 0;       // negative: never respond
  logic [31:0] m_data = 32'd0;
  logic [31:0] exp_maddr = 32'd0, exp_mwd = 32'd0;
  logic        exp_mwe = 1'b0;
  int          gnt_cyc = 0;
  int          force_req = 0;  // bump to request a stray mem_rvalid pulse

  int          mdl_req_c = 0, mdl_resp_c = 0, mdl_force_ack = 0;
  bit          mdl_resp_act = 1'b0;

  initial begin
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'd0;
    forever begin
      @(posedge clk); #1;
      mem_ready  = 1'b0;
      mem_rvalid = 1'b0;
      if (!rst_n) begin
        mdl_req_c    = 0;
        mdl_resp_act = 1'b0;
      end else begin
        if (force_req != mdl_force_ack) begin
          mdl_force_ack = force_req;
          mem_rvalid    = 1'b1;
          mem_rdata     = 32'h0BAD_F00D;
        end
        if (mdl_resp_act) begin
          if (m_rv >= 0 && mdl_resp_c == m_rv) begin
            mem_rvalid   = 1'b1;
            mem_rdata    = m_data;
            mdl_resp_act = 1'b0;
          end else begin
            mdl_resp_c++;
          end
        end
        if (mem_req) begin
          if (mdl_req_c == 0) check_eq("mem_req_latency", cyc - gnt_cyc, 1);
          check_eq("mem_addr", mem_addr, exp_maddr);
          check_eq("mem_we", 32'(mem_we), 32'(exp_mwe));
          check_eq("mem_wd", mem_wd, exp_mwd);
          if (mdl_req_c == m_rdy) begin
            mem_ready    = 1'b1;
            mdl_req_c    = 0;
            mdl_resp_act = 1'b1;
            mdl_resp_c   = 0;
          end else begin
            mdl_req_c++;
          end
        end
      end
    end
  end

  exp_t        mon_e;
  logic [31:0] last_if = 32'd0, last_ls = 32'd0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_if = 32'd0;
        last_ls = 32'd0;
      end else if (if_rvalid || ls_rvalid) begin
        if (sb.size() == 0) begin
          check_eq("unexpected_rvalid", {30'd0, ls_rvalid, if_rvalid}, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check_eq("owner_is_ls", 32'(ls_rvalid), 32'(mon_e.ls));
          check_eq("both_rvalid", 32'(if_rvalid & ls_rvalid), 32'd0);
          check_eq("latency", cyc - gnt_cyc, mon_e.lat);
          if (mon_e.ls) begin
            check_eq("ls_rdata", ls_rdata, mon_e.data);
            check_eq("ls_err", 32'(ls_err), 32'(mon_e.err));
            check_eq("if_err_nonowner", 32'(if_err), 32'd0);
            check_eq("if_rdata_hold", if_rdata, last_if);
            last_ls = mon_e.data;
          end else begin
            check_eq("if_rdata", if_rdata, mon_e.data);
            check_eq("if_err", 32'(if_err), 32'(mon_e.err));
            check_eq("ls_err_nonowner", 32'(ls_err), 32'd0);
            check_eq("ls_rdata_hold", ls_rdata, last_ls);
            last_if = mon_e.data;
          end
        end
      end
    end
  end

  task automatic run_txn(input bit rq_if, input bit rq_ls, input bit exp_ls,
                         input logic [31:0] a_if, input logic [31:0] a_ls,
                         input bit we, input logic [31:0] wd,
                         input int rdy, input int rv,
                         input logic [31:0] data);
    int   n;
    exp_t e;
    m_rdy     = rdy;
    m_rv      = rv;
    m_data    = data;
    exp_maddr = exp_ls ? a_ls : a_if;
    exp_mwe   = exp_ls & we;
    exp_mwd   = exp_ls ? wd : 32'd0;
    e.ls   = exp_ls;
    e.err  = (rv < 0);
    e.data = (rv < 0) ? 32'd0 : data;
    e.lat  = (rv < 0) ? (2 + rdy + TIMEOUT) : (3 + rdy + rv);
    @(posedge clk); #1;
    if_req  = rq_if;
    if_addr = a_if;
    ls_req  = rq_ls;
    ls_addr = a_ls;
    ls_we   = we;
    ls_wd   = wd;
    @(negedge clk);
    n = 0;
    while (!(if_gnt || ls_gnt) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("gnt_seen", 32'(if_gnt | ls_gnt), 32'd1);
    check_eq("gnt_ls", 32'(ls_gnt), 32'(exp_ls));
    check_eq("gnt_if", 32'(if_gnt), 32'(!exp_ls));
    gnt_cyc = cyc;
    sb.push_back(e);
    @(posedge clk); #1;
    if_req = 1'b0;
    ls_req = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("response_arrived", sb.size(), 32'd0);
    if (sb.size() != 0) sb.delete();
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_ctl"}, {25'd0, if_gnt, if_rvalid, if_err, ls_gnt,
                             ls_rvalid, ls_err, mem_req}, 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check_quiet(tag);
    check_eq({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check_eq({tag, "_mem_addr"}, mem_addr, 32'd0);
    check_eq({tag, "_mem_wd"}, mem_wd, 32'd0);
    check_eq({tag, "_if_rdata"}, if_rdata, 32'd0);
    check_eq({tag, "_ls_rdata"}, ls_rdata, 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit exp_ls;
    rst_n = 1'b0;
    if_req = 1'b0; if_addr = 32'd0;
    ls_req = 1'b0; ls_addr = 32'd0; ls_we = 1'b0; ls_wd = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("idle");

    // Minimum-latency fetch.
    run_txn(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 1'b0, 32'h0, 0, 0, 32'hDEADBEEF);

    // Simultaneous requests, last grant was a fetch.
    for (int i = 0; i < 4; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_ls = (i % 2 == 0);
`else
      exp_ls = 1'b1;
`endif
      run_txn(1'b1, 1'b1, exp_ls, 32'h400 + 32'(i * 4), 32'h800 + 32'(i * 4),
              1'b0, 32'h0, 0, 1, 32'h1000 + 32'(i));
    end

    // ls load with delayed ready and response.
    run_txn(1'b0, 1'b1, 1'b1, 32'h0, 32'h3000, 1'b0, 32'h0, 1, 2, 32'hCAFEF00D);

    // Store held through 3 not-ready cycles; ack data passes through.
    run_txn(1'b0, 1'b1, 1'b1, 32'h0, 32'h2000, 1'b1, 32'h55, 3, 0, 32'h0000ACED);

    // Fetch timeout, then an immediate fetch proves the FSM returned to IDLE.
    run_txn(1'b1, 1'b0, 1'b0, 32'h500, 32'h0, 1'b0, 32'h0, 0, -1, 32'hFFFF0000);
    run_txn(1'b1, 1'b0, 1'b0, 32'h504, 32'h0, 1'b0, 32'h0, 0, 0, 32'h13572468);

    // Response in the cycle the counter expires: normal response.
    run_txn(1'b0, 1'b1, 1'b1, 32'h0, 32'h510, 1'b0, 32'h0, 1, TIMEOUT - 1,
            32'h33333333);

    // Stray mem_rvalid while idle is ignored.
    force_req++;
    repeat (4) begin
      @(negedge clk);
      check_quiet("idle_stray_rvalid");
    end

    // Reset while in RESP abandons the transaction.
    m_rdy = 0; m_rv = -1; m_data = 32'h66666666;
    exp_maddr = 32'h600; exp_mwe = 1'b0; exp_mwd = 32'h0;
    @(posedge clk); #1;
    ls_req = 1'b1; ls_addr = 32'h600; ls_we = 1'b0;
    @(negedge clk);
    check_eq("rst_txn_gnt", 32'(ls_gnt), 32'd1);
    gnt_cyc = cyc;
    @(posedge clk); #1;
    ls_req = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_reset_vals("async_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    force_req++;
    repeat (6) begin
      @(negedge clk);
      check_reset_vals("after_reset");
    end

    // Normal operation resumes after reset.
    run_txn(1'b1, 1'b0, 1'b0, 32'h700, 32'h0, 1'b0, 32'h0, 0, 0, 32'h77777777);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
